// File: rtl/dot_product_n.sv
// Fixed-point dot product of an activation vector against constant weights,
// computed over L parallel multiply lanes with a final lane reduction.
module dot_product_n #(
  parameter int W    = 16,
  parameter int N    = 8,
  parameter int L    = 2,
  parameter int FRAC = 8,
  // N words of W bits, b[0] in the least-significant word
  parameter logic [N*W-1:0] B_VALUES = '0,
  localparam int ACC_W = 2*W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0][W-1:0]     a,
  input  logic                    in_v,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_full,
  output logic [W-1:0]            out,
  output logic                    out_v,
  input  logic                    out_ready
);

  if (L < 1 || L > N) begin : g_bad_l
    $error("dot_product_n: L must be in 1..N");
  end
  if (N % L != 0) begin : g_bad_n
    $error("dot_product_n: N must be a multiple of L");
  end

  localparam int STEPS  = N / L;
  localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, MULT, FINAL_ADD, REDUCE, DONE} state_t;

  state_t state, state_next;

  logic [N-1:0][W-1:0]     a_reg;
  logic [N-1:0][W-1:0]     b_reg;
  logic [STEP_W-1:0]       step;
  logic signed [2*W-1:0]   prod [L];
  logic signed [ACC_W-1:0] acc  [L];
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] shifted;
  logic [W-1:0]            sat_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_v) state_next = MULT;
      end
      MULT:      if (step == LAST_STEP) state_next = FINAL_ADD;
      FINAL_ADD: state_next = REDUCE;
      REDUCE:    state_next = DONE;
      DONE:      if (out_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Lane reduction and narrowing: floor shift, then clamp to the W-bit range.
  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < L; j++) lane_sum = lane_sum + acc[j];
    shifted = lane_sum >>> FRAC;
    if (shifted > SAT_MAX)      sat_out = {1'b0, {(W-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_out = {1'b1, {(W-1){1'b0}}};
    else                        sat_out = shifted[W-1:0];
  end

  // Operands shift down by L words each step so lane j always reads word j.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      step     <= '0;
      out_full <= '0;
      out      <= '0;
      out_v    <= 1'b0;
      for (int j = 0; j < L; j++) begin
        prod[j] <= '0;
        acc[j]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_v) begin
            a_reg <= a;
            b_reg <= B_VALUES;
            step  <= '0;
            for (int j = 0; j < L; j++) begin
              prod[j] <= '0;
              acc[j]  <= '0;
            end
          end
        end
        MULT: begin
          for (int j = 0; j < L; j++) begin
            prod[j] <= (2*W)'($signed(a_reg[j])) * (2*W)'($signed(b_reg[j]));
            acc[j]  <= acc[j] + ACC_W'(prod[j]);
          end
          for (int i = 0; i < N - L; i++) begin
            a_reg[i] <= a_reg[i+L];
            b_reg[i] <= b_reg[i+L];
          end
          step <= step + STEP_W'(1);
        end
        FINAL_ADD: begin
          for (int j = 0; j < L; j++) acc[j] <= acc[j] + ACC_W'(prod[j]);
        end
        REDUCE: begin
          out_full <= lane_sum;
          out      <= sat_out;
          out_v    <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_n.sv
// Directed bench for dot_product_n: three N=4/L=2 instances with different weights
// share one stimulus port set; two N=8 instances (L=1, L=8) share another.
module tb_dot_product_n;

  logic clk;
  logic rst;

  logic [3:0][15:0] a4;
  logic             in_v4, out_ready4;
  logic             main_in_ready, main_v, satp_in_ready, satp_v, satn_in_ready, satn_v;
  logic [33:0]      main_full, satp_full, satn_full;
  logic [15:0]      main_out, satp_out, satn_out;

  logic [7:0][15:0] a8;
  logic             in_v8, out_ready8;
  logic             l1_in_ready, l1_v, l8_in_ready, l8_v;
  logic [34:0]      l1_full, l8_full;
  logic [15:0]      l1_out, l8_out;

  localparam logic [127:0] B8 = {16'hEDCB, 16'h1234, 16'hFFFD, 16'h0003,
                                 16'h8000, 16'h7FFF, 16'hFF80, 16'h0100};
  logic [7:0][15:0] b8;

  int vectors;
  int miscompares;

  dot_product_n #(.W(16), .N(4), .L(2), .FRAC(8), .B_VALUES(64'h0080_FF00_0200_0100)) u_main (
    .clk(clk), .rst(rst), .a(a4), .in_v(in_v4), .in_ready(main_in_ready),
    .out_full(main_full), .out(main_out), .out_v(main_v), .out_ready(out_ready4));

  dot_product_n #(.W(16), .N(4), .L(2), .FRAC(8), .B_VALUES(64'h7FFF_7FFF_7FFF_7FFF)) u_satp (
    .clk(clk), .rst(rst), .a(a4), .in_v(in_v4), .in_ready(satp_in_ready),
    .out_full(satp_full), .out(satp_out), .out_v(satp_v), .out_ready(out_ready4));

  dot_product_n #(.W(16), .N(4), .L(2), .FRAC(8), .B_VALUES(64'h8001_8001_8001_8001)) u_satn (
    .clk(clk), .rst(rst), .a(a4), .in_v(in_v4), .in_ready(satn_in_ready),
    .out_full(satn_full), .out(satn_out), .out_v(satn_v), .out_ready(out_ready4));

  dot_product_n #(.W(16), .N(8), .L(1), .FRAC(8), .B_VALUES(B8)) u_l1 (
    .clk(clk), .rst(rst), .a(a8), .in_v(in_v8), .in_ready(l1_in_ready),
    .out_full(l1_full), .out(l1_out), .out_v(l1_v), .out_ready(out_ready8));

  dot_product_n #(.W(16), .N(8), .L(8), .FRAC(8), .B_VALUES(B8)) u_l8 (
    .clk(clk), .rst(rst), .a(a8), .in_v(in_v8), .in_ready(l8_in_ready),
    .out_full(l8_full), .out(l8_out), .out_v(l8_v), .out_ready(out_ready8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Accepts vec on the next edge, then scrambles a4 and counts edges until out_v.
  task automatic run_main(input logic [3:0][15:0] vec, output int edges);
    bit found;
    a4    = vec;
    in_v4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_v4 = 1'b0;
    a4    = {4{16'h5A5A}};
    edges = 0;
    found = 1'b0;
    while (!found && edges < 30) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      found = main_v;
    end
    if (!found) edges = -1;
  endtask

  task automatic consume4();
    out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (main_v !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_v: got %b expected 0", main_v);
    end
    vectors++;
    if (main_out !== 16'h0000) begin
      miscompares++; $display("[TB] FAIL reset_out: got %h expected 0000", main_out);
    end
    vectors++;
    if (main_full !== 34'h0) begin
      miscompares++; $display("[TB] FAIL reset_out_full: got %h expected 0", main_full);
    end
    vectors++;
    if (main_in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", main_in_ready);
    end
    vectors++;
    if (l1_v !== 1'b0 || l8_v !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_lane_out_v: got %b%b expected 00", l1_v, l8_v);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int edges;
    run_main({16'h0200, 16'h0100, 16'h0100, 16'h0100}, edges);
    vectors++;
    if (edges !== 4) begin
      miscompares++; $display("[TB] FAIL basic_latency: got %0d expected 4", edges);
    end
    vectors++;
    if (main_full !== 34'h0_0003_0000) begin
      miscompares++; $display("[TB] FAIL basic_out_full: got %h expected 30000", main_full);
    end
    vectors++;
    if (main_out !== 16'h0300) begin
      miscompares++; $display("[TB] FAIL basic_out: got %h expected 0300", main_out);
    end
    vectors++;
    if (main_in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL basic_in_ready_done: got %b expected 0", main_in_ready);
    end
    consume4();
    vectors++;
    if (main_v !== 1'b0 || main_in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_consume: got out_v=%b in_ready=%b expected 0/1", main_v, main_in_ready);
    end
    vectors++;
    if (main_out !== 16'h0300) begin
      miscompares++; $display("[TB] FAIL basic_out_kept: got %h expected 0300", main_out);
    end
  endtask

  task automatic test_saturation();
    int edges;
    run_main({4{16'h7FFF}}, edges);
    vectors++;
    if (edges !== 4) begin
      miscompares++; $display("[TB] FAIL sat_latency: got %0d expected 4", edges);
    end
    vectors++;
    if (satp_out !== 16'h7FFF) begin
      miscompares++; $display("[TB] FAIL sat_pos_out: got %h expected 7fff", satp_out);
    end
    vectors++;
    if (satp_full !== 34'h0_FFFC_0004) begin
      miscompares++; $display("[TB] FAIL sat_pos_full: got %h expected 0fffc0004", satp_full);
    end
    vectors++;
    if (satn_out !== 16'h8000) begin
      miscompares++; $display("[TB] FAIL sat_neg_out: got %h expected 8000", satn_out);
    end
    vectors++;
    if (satn_full !== 34'h3_0003_FFFC) begin
      miscompares++; $display("[TB] FAIL sat_neg_full: got %h expected 30003fffc", satn_full);
    end
    consume4();
  endtask

  task automatic test_backpressure();
    int edges;
    run_main({16'h0200, 16'h0100, 16'h0100, 16'h0100}, edges);
    vectors++;
    if (edges !== 4) begin
      miscompares++; $display("[TB] FAIL bp_latency: got %0d expected 4", edges);
    end
    in_v4 = 1'b1;
    a4    = {4{16'h1111}};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (main_v !== 1'b1 || main_out !== 16'h0300 || main_in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold cycle %0d: got out_v=%b out=%h in_ready=%b expected 1/0300/0",
                 c, main_v, main_out, main_in_ready);
      end
    end
    out_ready4 = 1'b1;
    in_v4      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready4 = 1'b0;
    vectors++;
    if (main_v !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_consume: got out_v=%b expected 0", main_v);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    int edges;
    a4    = {16'h0200, 16'h0100, 16'h0100, 16'h0100};
    in_v4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_v4 = 1'b0;
    a4    = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (main_v === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("[TB] FAIL abort_out_v: got out_v=1 after reset expected 0");
    end
    vectors++;
    if (main_full !== 34'h0) begin
      miscompares++; $display("[TB] FAIL abort_out_full: got %h expected 0", main_full);
    end
    run_main({16'h0200, 16'h0100, 16'h0100, 16'h0100}, edges);
    vectors++;
    if (edges !== 4 || main_full !== 34'h0_0003_0000) begin
      miscompares++;
      $display("[TB] FAIL abort_recover: got latency=%0d full=%h expected 4/30000", edges, main_full);
    end
    consume4();
  endtask

  task automatic test_back_to_back();
    logic [3:0][15:0] vec [5];
    logic [33:0]      exp_full [5];
    logic [15:0]      exp_out [5];
    int next_in, next_out, last_cyc;
    vec[0] = {16'h0200, 16'h0100, 16'h0100, 16'h0100}; exp_full[0] = 34'h0_0003_0000; exp_out[0] = 16'h0300;
    vec[1] = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; exp_full[1] = 34'h0_0000_0000; exp_out[1] = 16'h0000;
    vec[2] = {16'h0000, 16'h0100, 16'h0000, 16'h0000}; exp_full[2] = 34'h3_FFFF_0000; exp_out[2] = 16'hFF00;
    vec[3] = {16'h0000, 16'h0000, 16'h0040, 16'h0080}; exp_full[3] = 34'h0_0001_0000; exp_out[3] = 16'h0100;
    vec[4] = {16'hFFFF, 16'h0000, 16'h0000, 16'h0000}; exp_full[4] = 34'h3_FFFF_FF80; exp_out[4] = 16'hFFFF;
    next_in    = 0;
    next_out   = 0;
    last_cyc   = -1;
    in_v4      = 1'b1;
    out_ready4 = 1'b1;
    for (int cyc = 0; cyc < 80 && next_out < 5; cyc++) begin
      if (main_v === 1'b1) begin
        vectors++;
        if (main_full !== exp_full[next_out] || main_out !== exp_out[next_out]) begin
          miscompares++;
          $display("[TB] FAIL b2b_result %0d: got full=%h out=%h expected %h/%h",
                   next_out, main_full, main_out, exp_full[next_out], exp_out[next_out]);
        end
        if (next_out > 0) begin
          vectors++;
          if (cyc - last_cyc != 6) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing %0d: got %0d expected 6", next_out, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        next_out++;
      end
      if (main_in_ready === 1'b1) begin
        if (next_in < 5) begin
          a4 = vec[next_in];
          next_in++;
        end else begin
          in_v4 = 1'b0;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_v4      = 1'b0;
    out_ready4 = 1'b0;
    vectors++;
    if (next_out != 5) begin
      miscompares++; $display("[TB] FAIL b2b_count: got %0d results expected 5", next_out);
    end
    repeat (8) @(negedge clk);
    if (main_v === 1'b1) consume4();
  endtask

  task automatic test_lane_variants();
    longint s, sh;
    logic [15:0] exp_out;
    int lat1, lat8;
    b8 = B8;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 8; i++) a8[i] = (it == 0) ? 16'h8000 : 16'($urandom);
      s = 0;
      for (int i = 0; i < 8; i++) s += longint'($signed(a8[i])) * longint'($signed(b8[i]));
      sh = s >>> 8;
      if (sh > 32767)       exp_out = 16'h7FFF;
      else if (sh < -32768) exp_out = 16'h8000;
      else                  exp_out = 16'(sh);
      in_v8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_v8 = 1'b0;
      a8    = '0;
      lat1  = -1;
      lat8  = -1;
      for (int e = 1; e <= 15; e++) begin
        @(posedge clk);
        @(negedge clk);
        if (l1_v === 1'b1 && lat1 < 0) lat1 = e;
        if (l8_v === 1'b1 && lat8 < 0) lat8 = e;
      end
      vectors++;
      if (lat1 != 10) begin
        miscompares++; $display("[TB] FAIL l1_latency it%0d: got %0d expected 10", it, lat1);
      end
      vectors++;
      if (lat8 != 3) begin
        miscompares++; $display("[TB] FAIL l8_latency it%0d: got %0d expected 3", it, lat8);
      end
      vectors++;
      if (l1_full !== 35'(s) || l1_out !== exp_out) begin
        miscompares++;
        $display("[TB] FAIL l1_result it%0d: got %h/%h expected %h/%h", it, l1_full, l1_out, 35'(s), exp_out);
      end
      vectors++;
      if (l8_full !== 35'(s) || l8_out !== exp_out) begin
        miscompares++;
        $display("[TB] FAIL l8_result it%0d: got %h/%h expected %h/%h", it, l8_full, l8_out, 35'(s), exp_out);
      end
      out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready8 = 1'b0;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    a4          = '0;
    in_v4       = 1'b0;
    out_ready4  = 1'b0;
    a8          = '0;
    in_v8       = 1'b0;
    out_ready8  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_lane_variants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
